// File: rtl/wbu_buf_pkg.sv
// Shared types and sizing helpers for the writeback buffer.
// Global datapath widths fall back to RV64 values when no defines file is present.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif
`ifndef REG_ADDRW
`define REG_ADDRW 5
`endif
`ifndef CSR_ADDRW
`define CSR_ADDRW 12
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

package wbu_buf_pkg;

    localparam int unsigned CPU_W  = `CPU_WIDTH;
    localparam int unsigned REG_AW = `REG_ADDRW;
    localparam int unsigned CSR_AW = `CSR_ADDRW;
    localparam int unsigned INS_W  = `INS_WIDTH;

    // rd is stored already resolved between the ALU and load results.
    typedef struct packed {
        logic [CPU_W-1:0]  rd;
        logic [REG_AW-1:0] rdid;
        logic              rdwen;
        logic [CSR_AW-1:0] csrdid;
        logic              csrdwen;
        logic [CPU_W-1:0]  csrd;
        logic [CPU_W-1:0]  pc;
        logic [INS_W-1:0]  ins;
        logic              nop;
        logic              lsclint;
        logic              uart;
    } wbu_buf_ent_t;

    function automatic int unsigned wbu_buf_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wbu_buf_fwd.sv
// Youngest-match forwarding search over the buffered entries for one query port.
module wbu_buf_fwd
    import wbu_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic [CPU_W-1:0]             i_rd    [DEPTH],
    input  logic [REG_AW-1:0]            i_rdid  [DEPTH],
    input  logic [DEPTH-1:0]             i_rdwen,
    input  logic [$clog2(DEPTH)-1:0]     i_rptr,
    input  logic [$clog2(DEPTH):0]       i_count,
    input  logic [REG_AW-1:0]            i_rsid,
    output logic                         o_hit,
    output logic [CPU_W-1:0]             o_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = wbu_buf_cnt_w(DEPTH);

    logic [CPU_W-1:0]  w_rd_ord [DEPTH];
    logic [REG_AW-1:0] w_id_ord [DEPTH];
    logic [DEPTH-1:0]  w_en_ord;

    // Reorder slots by age so index 0 is the head and DEPTH-1 the youngest possible.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ord
        localparam logic [PW-1:0] AGE = PW'(g);
        assign w_rd_ord[g] = i_rd[i_rptr + AGE];
        assign w_id_ord[g] = i_rdid[i_rptr + AGE];
        assign w_en_ord[g] = i_rdwen[i_rptr + AGE] & (CW'(g) < i_count);
    end

    // Later iterations are younger, so the last match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_en_ord[i] && (w_id_ord[i] == i_rsid) && (i_rsid != '0)) begin
                o_hit  = 1'b1;
                o_data = w_rd_ord[i];
            end
        end
    end

endmodule

// File: rtl/wbu_buf.sv
// Writeback buffer: small FIFO between LSU and register writeback with
// commit gating, retired-instruction counting and register forwarding.
module wbu_buf
    import wbu_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned NRS   = 2,
    parameter int unsigned CNT_W = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_flush,
    input  logic                           i_pre_valid,
    output logic                           o_pre_ready,
    output logic                           o_post_valid,
    input  logic                           i_post_ready,
    input  logic [CPU_W-1:0]               i_lsu_exres,
    input  logic [CPU_W-1:0]               i_lsu_lsres,
    input  logic [CPU_W-1:0]               i_lsu_csrd,
    input  logic [CPU_W-1:0]               i_lsu_pc,
    input  logic                           i_lsu_lden,
    input  logic                           i_lsu_rdwen,
    input  logic                           i_lsu_csrdwen,
    input  logic                           i_lsu_nop,
    input  logic                           s_lsu_lsclint,
    input  logic                           s_lsu_uart,
    input  logic [REG_AW-1:0]              i_lsu_rdid,
    input  logic [CSR_AW-1:0]              i_lsu_csrdid,
    input  logic [INS_W-1:0]               i_lsu_ins,
    input  logic                           i_iru_intr,
    output logic [REG_AW-1:0]              o_wbu_rdid,
    output logic                           o_wbu_rdwen,
    output logic [CPU_W-1:0]               o_wbu_rd,
    output logic [CSR_AW-1:0]              o_wbu_csrdid,
    output logic                           o_wbu_csrdwen,
    output logic [CPU_W-1:0]               o_wbu_csrd,
    output logic                           o_wbu_commit,
    output logic [CPU_W-1:0]               o_wbu_pc,
    output logic [INS_W-1:0]               o_wbu_ins,
    output logic                           o_wbu_nop,
    output logic                           s_wbu_lsclint,
    output logic                           s_wbu_uart,
    input  logic [REG_AW-1:0]              i_hz_rsid [NRS],
    output logic                           o_hz_hit  [NRS],
    output logic [CPU_W-1:0]               o_hz_data [NRS],
    output logic [wbu_buf_cnt_w(DEPTH)-1:0] o_count,
    output logic [CNT_W-1:0]               o_instret
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = wbu_buf_cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wbu_buf_ent_t     r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_instret;

    wbu_buf_ent_t w_new;
    wbu_buf_ent_t w_head;
    logic         w_push;
    logic         w_pop;
    logic         w_commit;

    logic [CPU_W-1:0]  w_ent_rd    [DEPTH];
    logic [REG_AW-1:0] w_ent_rdid  [DEPTH];
    logic [DEPTH-1:0]  w_ent_rdwen;

    assign o_post_valid = (r_count != '0);
    assign w_pop        = o_post_valid & i_post_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign o_pre_ready  = (r_count != FULL) | w_pop;
    assign w_push       = i_pre_valid & o_pre_ready;
    assign w_commit     = w_pop & ~i_iru_intr;

    always_comb begin
        w_new         = '0;
        w_new.rd      = i_lsu_lden ? i_lsu_lsres : i_lsu_exres;
        w_new.rdid    = i_lsu_rdid;
        w_new.rdwen   = i_lsu_rdwen;
        w_new.csrdid  = i_lsu_csrdid;
        w_new.csrdwen = i_lsu_csrdwen;
        w_new.csrd    = i_lsu_csrd;
        w_new.pc      = i_lsu_pc;
        w_new.ins     = i_lsu_ins;
        w_new.nop     = i_lsu_nop;
        w_new.lsclint = s_lsu_lsclint;
        w_new.uart    = s_lsu_uart;
    end

    assign w_head = o_post_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_new;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Survives flush: only reset clears the retired count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instret <= '0;
        end else if (w_commit && !w_head.nop) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_instret = r_instret;

    assign o_wbu_commit  = w_commit;
    assign o_wbu_rd      = w_head.rd;
    assign o_wbu_rdid    = w_head.rdid;
    assign o_wbu_rdwen   = w_commit & w_head.rdwen;
    assign o_wbu_csrdid  = w_head.csrdid;
    assign o_wbu_csrdwen = w_commit & w_head.csrdwen;
    assign o_wbu_csrd    = w_head.csrd;
    assign o_wbu_pc      = w_head.pc;
    assign o_wbu_ins     = w_head.ins;
    assign o_wbu_nop     = w_head.nop;
    assign s_wbu_lsclint = w_head.lsclint;
    assign s_wbu_uart    = w_head.uart;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign w_ent_rd[g]    = r_mem[g].rd;
        assign w_ent_rdid[g]  = r_mem[g].rdid;
        assign w_ent_rdwen[g] = r_mem[g].rdwen;
    end

    for (genvar k = 0; k < NRS; k++) begin : g_fwd
        wbu_buf_fwd #(
            .DEPTH (DEPTH)
        ) u_fwd (
            .i_rd    (w_ent_rd),
            .i_rdid  (w_ent_rdid),
            .i_rdwen (w_ent_rdwen),
            .i_rptr  (r_rptr),
            .i_count (r_count),
            .i_rsid  (i_hz_rsid[k]),
            .o_hit   (o_hz_hit[k]),
            .o_data  (o_hz_data[k])
        );
    end

endmodule
